// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32i pipeline.
// It drives the stall and flush controls for the PC, IF/ID, ID/EX and EX/MEM
// registers. It handles load-use hazards, mispredict redirects and data-memory
// wait states. A wait watchdog and saturating performance counters are included.
//
// Ports:
//   CLK, RST                      clock; synchronous active-high reset
//   Rs1_D, Rs2_D, Use_Rs1_D/Rs2_D decode-stage source operands and their use flags
//   Rd_E, Mem_Read_E              execute-stage destination and load flag
//   Mispredict_E                  EX-resolved branch/jump disagrees with prediction
//   Imem_Ready, Dmem_Busy         instruction / data memory handshakes
//   Stall_F/D/E/M, Flush_D/E      same-cycle pipeline controls (combinational)
//   Timeout_Err                   sticky watchdog error (registered)
//   Stall_Count, Flush_Count      saturating counters of stall cycles / mispredict flushes
module pipeline_hazard_ctrl #(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic             Use_Rs1_D,
    input  logic             Use_Rs2_D,
    input  logic [4:0]       Rd_E,
    input  logic             Mem_Read_E,
    input  logic             Mispredict_E,
    input  logic             Imem_Ready,
    input  logic             Dmem_Busy,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Timeout_Err,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                timeout_q;
    logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;
    logic                load_use;
    logic                redirect;

    // Rd_E = x0 never carries a real result, so it can never create a hazard.
    assign load_use = Mem_Read_E && (Rd_E != 5'd0) &&
                      ((Use_Rs1_D && (Rs1_D == Rd_E)) || (Use_Rs2_D && (Rs2_D == Rd_E)));

    // Priority decode of the pipeline controls; first matching condition wins.
    always_comb begin
        Stall_F  = 1'b0;
        Stall_D  = 1'b0;
        Stall_E  = 1'b0;
        Stall_M  = 1'b0;
        Flush_D  = 1'b0;
        Flush_E  = 1'b0;
        redirect = 1'b0;
        if (RST) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
        end else if (state_q == ST_HALT || Dmem_Busy) begin
            // EX is frozen, so a pending mispredict is re-presented on release.
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
        end else if (Mispredict_E) begin
            Flush_D  = 1'b1;
            Flush_E  = 1'b1;
            redirect = 1'b1;
        end else if (load_use) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
        end else if (!Imem_Ready) begin
            Stall_F = 1'b1;
            Flush_D = 1'b1;
        end
    end

    // Next state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_RUN: begin
                wait_d = '0;
                if (Dmem_Busy) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (!Dmem_Busy) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    // Compare in 9 bits so WAIT_LIMIT=255 cannot alias through wrap.
                    if (({1'b0, wait_q} + 9'd1) >= 9'(WAIT_LIMIT)) state_d = ST_HALT;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // State, watchdog flag and saturating counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_RUN;
            wait_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_q | (state_d == ST_HALT);
            if (Stall_D && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (redirect && (flush_cnt_q != {CNT_W{1'b1}}))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign Timeout_Err = timeout_q;
    assign Stall_Count = stall_cnt_q;
    assign Flush_Count = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32i pipeline. It generates stall and flush controls for the fetch PC, the IF/ID register (Stall_En, Flush_D), the ID/EX register and the EX/MEM register. It resolves load-use hazards, branch mispredict redirects and data-memory wait states, with a wait watchdog and saturating performance counters.

Parameters:
WAIT_LIMIT, 16, max consecutive Dmem_Busy cycles before timeout error (1..255)
CNT_W, 32, width of performance counters

Ports:
CLK  in  1  clock; all state updates on posedge
RST  in  1  synchronous, active-high reset
Rs1_D  in  5  decode-stage source register 1
Rs2_D  in  5  decode-stage source register 2
Use_Rs1_D  in  1  decode instruction reads Rs1
Use_Rs2_D  in  1  decode instruction reads Rs2
Rd_E  in  5  execute-stage destination register
Mem_Read_E  in  1  execute-stage instruction is a load
Mispredict_E  in  1  branch/jump resolved in EX disagrees with prediction
Imem_Ready  in  1  instruction memory has valid data this cycle
Dmem_Busy  in  1  data memory cannot complete MEM-stage access this cycle
Stall_F  out  1  hold PC
Stall_D  out  1  hold IF/ID (drives Stall_En)
Stall_E  out  1  hold ID/EX
Stall_M  out  1  hold EX/MEM
Flush_D  out  1  insert NOP into IF/ID
Flush_E  out  1  insert bubble into ID/EX
Timeout_Err  out  1  sticky watchdog error
Stall_Count  out  CNT_W  cycles with Stall_D=1
Flush_Count  out  CNT_W  mispredict flush events

Behaviour:
- Control outputs are combinational from current state and inputs, taking effect in the same cycle. Counters, state and Timeout_Err are registered.
- While RST=1: Stall_F/D/E/M=0, Flush_D=1, Flush_E=1. On the next edge: state=RUN, wait counter=0, Timeout_Err=0, both counters=0.
- FSM states: RUN, MEM_WAIT, HALT.
  - RUN -> MEM_WAIT when Dmem_Busy=1.
  - MEM_WAIT -> RUN when Dmem_Busy=0.
  - MEM_WAIT -> HALT when the wait counter reaches WAIT_LIMIT with Dmem_Busy still 1.
  - HALT is exited only by RST.
- Wait counter: 8-bit. Cleared in RUN. Increments each MEM_WAIT cycle with Dmem_Busy=1.
- Decodes are evaluated in priority order; the first match sets the outputs:
  1. state=HALT: all Stall_*=1, no flushes, Timeout_Err=1.
  2. Dmem_Busy=1 (RUN or MEM_WAIT): all Stall_*=1, no flushes. Mispredict_E is ignored because EX is frozen and re-presents it on release.
  3. Mispredict_E=1: Flush_D=1, Flush_E=1, all stalls 0. Mispredict overrides load-use and Imem_Ready.
  4. Load-use: Mem_Read_E=1 and Rd_E!=0 and ((Use_Rs1_D and Rs1_D==Rd_E) or (Use_Rs2_D and Rs2_D==Rd_E)). Outputs: Stall_F=1, Stall_D=1, Flush_E=1, exactly one cycle per hazard.
  5. Imem_Ready=0: Stall_F=1, Flush_D=1 (bubble into decode). Stall_D=0.
  6. Otherwise all outputs 0.
- Rd_E=0 never causes a load-use stall.
- Stall_Count increments on every non-reset cycle with Stall_D=1. Flush_Count increments on every non-reset cycle where rule 3 fires. Both saturate at all-ones and do not wrap.
- Timeout_Err rises on the edge entering HALT and stays high until RST.
- RST asserted mid-MEM_WAIT or in HALT returns to RUN on the next edge with counters cleared.

Test Plan:
- Load-use: Mem_Read_E=1, Rd_E=5, Rs1_D=5, Use_Rs1_D=1 for 1 cycle -> Stall_F=Stall_D=Flush_E=1 that cycle only; Stall_Count=1 afterwards. Repeat with Rd_E=0 -> no stall.
- Mispredict with a concurrent load-use condition -> Flush_D=Flush_E=1, Stall_F=Stall_D=0; Flush_Count increments by 1, Stall_Count unchanged.
- Dmem_Busy=1 for 3 cycles with Mispredict_E=1 throughout -> all stalls=1 and no flush for 3 cycles; then Dmem_Busy=0 -> Flush_D=Flush_E=1 in cycle 4; state back in RUN.
- WAIT_LIMIT=4, Dmem_Busy held high -> HALT after the 4th counted wait cycle; Timeout_Err=1 and all stalls stay 1 after Dmem_Busy drops; RST -> Timeout_Err=0, RUN.
- Imem_Ready=0 for 2 cycles, no other hazards -> Stall_F=1, Flush_D=1, Stall_D=0 each cycle; Stall_Count unchanged.
- CNT_W=4, hold load-use for 20 cycles -> Stall_Count saturates at 15. Assert RST during the run -> all outputs take reset values and both counters read 0 after the edge.
